// File: rtl/riscvbc_icache_dm.sv
// Direct-mapped, blocking, read-allocate instruction cache with multi-word lines.
// Reads refill word-by-word on a miss; writes go through to memory without allocating.
module riscvbc_icache_dm #(
    parameter int p_num_lines      = 16,
    parameter int p_words_per_line = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic [66:0] memreq_msg,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic [34:0] memresp_msg,
    output logic        cachereq_val,
    input  logic        cachereq_rdy,
    output logic [66:0] cachereq_msg,
    input  logic        cacheresp_val,
    output logic        cacheresp_rdy,
    input  logic [34:0] cacheresp_msg,
    input  logic        flush,
    output logic        flush_done
);

    localparam int OFF_W = $clog2(p_words_per_line);
    localparam int IDX_W = $clog2(p_num_lines);
    localparam int TAG_W = 32 - IDX_W - OFF_W - 2;

    typedef enum logic [2:0] {
        IDLE, TAG, REFILL_REQ, REFILL_WAIT, WR_REQ, WR_WAIT, RESP, FLUSH
    } state_t;

    state_t state, state_next;

    logic [66:0]      req_q;
    logic             req_type;
    logic [1:0]       req_len;
    logic [31:0]      req_addr;
    logic [31:0]      req_data;
    logic [OFF_W-1:0] req_off;
    logic [IDX_W-1:0] req_idx;
    logic [TAG_W-1:0] req_tag;

    logic [OFF_W-1:0]       word_cnt;
    logic [IDX_W-1:0]       flush_cnt;
    logic                   flush_pending;
    logic [p_num_lines-1:0] valid_q;
    logic [TAG_W-1:0]       tag_q  [p_num_lines];
    logic [31:0]            data_q [p_num_lines*p_words_per_line];
    logic [31:0]            resp_data;
    logic [31:0]            num_hits;
    logic [31:0]            num_misses;

    logic hit;
    logic last_word;
    logic last_line;
    logic unused_resp_bits;

    assign req_type  = req_q[66];
    assign req_addr  = req_q[65:34];
    assign req_len   = req_q[33:32];
    assign req_data  = req_q[31:0];
    assign req_off   = req_addr[OFF_W+1:2];
    assign req_idx   = req_addr[IDX_W+OFF_W+1:OFF_W+2];
    assign req_tag   = req_addr[31:IDX_W+OFF_W+2];

    assign hit       = valid_q[req_idx] && (tag_q[req_idx] == req_tag);
    assign last_word = (word_cnt == OFF_W'(p_words_per_line - 1));
    assign last_line = (flush_cnt == IDX_W'(p_num_lines - 1));

    assign unused_resp_bits = ^cacheresp_msg[34:32];

    always_ff @(posedge clk) begin
        if (reset) state <= IDLE;
        else       state <= state_next;
    end

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:        if (flush_pending || flush) state_next = FLUSH;
                         else if (memreq_val)        state_next = TAG;
            TAG:         if (req_type)               state_next = WR_REQ;
                         else if (hit)               state_next = RESP;
                         else                        state_next = REFILL_REQ;
            REFILL_REQ:  if (cachereq_rdy)           state_next = REFILL_WAIT;
            REFILL_WAIT: if (cacheresp_val)          state_next = last_word ? RESP : REFILL_REQ;
            WR_REQ:      if (cachereq_rdy)           state_next = WR_WAIT;
            WR_WAIT:     if (cacheresp_val)          state_next = RESP;
            RESP:        if (memresp_rdy)            state_next = IDLE;
            FLUSH:       if (last_line)              state_next = IDLE;
            default:                                 state_next = IDLE;
        endcase
    end

    // Handshake outputs are forced low while reset is held, before the state is known.
    always_comb begin
        memreq_rdy   = 1'b0;
        memresp_val  = 1'b0;
        cachereq_val = 1'b0;
        flush_done   = 1'b0;
        cachereq_msg = {1'b0, req_tag, req_idx, word_cnt, 2'b00, 2'b00, 32'b0};
        if (!reset) begin
            case (state)
                IDLE:       memreq_rdy   = !flush_pending && !flush;
                REFILL_REQ: cachereq_val = 1'b1;
                WR_REQ: begin
                    cachereq_val = 1'b1;
                    cachereq_msg = req_q;
                end
                RESP:       memresp_val  = 1'b1;
                FLUSH:      flush_done   = last_line;
                default: ;
            endcase
        end
    end

    assign memresp_msg   = {req_type, req_len, req_type ? 32'b0 : resp_data};
    assign cacheresp_rdy = 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q       <= '0;
            flush_pending <= 1'b0;
            flush_cnt     <= '0;
            word_cnt      <= '0;
            num_hits      <= '0;
            num_misses    <= '0;
        end else begin
            flush_pending <= flush || (flush_pending && !flush_done);
            case (state)
                IDLE: if (memreq_val && memreq_rdy) req_q <= memreq_msg;
                TAG: begin
                    if (!req_type) begin
                        if (hit) begin
                            num_hits  <= num_hits + 32'd1;
                            resp_data <= data_q[{req_idx, req_off}];
                        end else begin
                            num_misses <= num_misses + 32'd1;
                            word_cnt   <= '0;
                        end
                    end else if (hit && req_len != 2'b00) begin
                        valid_q[req_idx] <= 1'b0;
                    end
                end
                REFILL_WAIT: if (cacheresp_val) begin
                    if (word_cnt == req_off) resp_data <= cacheresp_msg[31:0];
                    if (last_word) valid_q[req_idx] <= 1'b1;
                    else           word_cnt <= word_cnt + 1'b1;
                end
                FLUSH: begin
                    valid_q[flush_cnt] <= 1'b0;
                    flush_cnt          <= flush_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    // NOTE: tag and data arrays are not reset; the valid bits alone make their contents meaningful.
    always_ff @(posedge clk) begin
        if (state == TAG && req_type && hit && req_len == 2'b00)
            data_q[{req_idx, req_off}] <= req_data;
        if (state == REFILL_WAIT && cacheresp_val) begin
            data_q[{req_idx, word_cnt}] <= cacheresp_msg[31:0];
            if (last_word) tag_q[req_idx] <= req_tag;
        end
    end

    cacheresp_in_wait_state: assert property (@(posedge clk) disable iff (reset)
        cacheresp_val |-> (state == REFILL_WAIT || state == WR_WAIT));

endmodule

// File: tb/tb_riscvbc_icache_dm.sv
// Directed bench for riscvbc_icache_dm: vector table for hit/miss/write traffic plus
// hand-written sequences for reset, backpressure and flush corner cases.
module tb_riscvbc_icache_dm;

    logic        clk = 1'b0;
    logic        reset;
    logic        memreq_val;
    logic        memreq_rdy;
    logic [66:0] memreq_msg;
    logic        memresp_val;
    logic        memresp_rdy;
    logic [34:0] memresp_msg;
    logic        cachereq_val;
    logic        cachereq_rdy;
    logic [66:0] cachereq_msg;
    logic        cacheresp_val;
    logic        cacheresp_rdy;
    logic [34:0] cacheresp_msg;
    logic        flush;
    logic        flush_done;

    riscvbc_icache_dm dut (
        .clk           (clk),
        .reset         (reset),
        .memreq_val    (memreq_val),
        .memreq_rdy    (memreq_rdy),
        .memreq_msg    (memreq_msg),
        .memresp_val   (memresp_val),
        .memresp_rdy   (memresp_rdy),
        .memresp_msg   (memresp_msg),
        .cachereq_val  (cachereq_val),
        .cachereq_rdy  (cachereq_rdy),
        .cachereq_msg  (cachereq_msg),
        .cacheresp_val (cacheresp_val),
        .cacheresp_rdy (cacheresp_rdy),
        .cacheresp_msg (cacheresp_msg),
        .flush         (flush),
        .flush_done    (flush_done)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [66:0] act, input logic [66:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Memory model: words never written read back as 0xD0000000 | addr.
    logic [31:0] mem_wr [logic [31:0]];
    logic [31:0] rd_log [$];
    int          wr_cnt = 0;
    logic [66:0] last_wr;
    logic        mem_fire;
    logic [66:0] mem_req;

    function automatic logic [31:0] mem_rd(input logic [31:0] a);
        if (mem_wr.exists(a)) return mem_wr[a];
        return 32'hD000_0000 | a;
    endfunction

    initial begin
        cacheresp_val = 1'b0;
        cacheresp_msg = '0;
        forever begin
            @(negedge clk);
            mem_fire = !reset && cachereq_val && cachereq_rdy;
            mem_req  = cachereq_msg;
            @(posedge clk);
            #1;
            cacheresp_val = 1'b0;
            if (mem_fire) begin
                cacheresp_val = 1'b1;
                if (mem_req[66]) begin
                    if (mem_req[33:32] == 2'b00) mem_wr[mem_req[65:34]] = mem_req[31:0];
                    wr_cnt++;
                    last_wr       = mem_req;
                    cacheresp_msg = {1'b1, 2'b00, 32'b0};
                end else begin
                    rd_log.push_back(mem_req[65:34]);
                    cacheresp_msg = {1'b0, 2'b00, mem_rd(mem_req[65:34])};
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic do_req(input logic typ, input logic [31:0] addr, input logic [1:0] len,
                          input logic [31:0] data, output logic [34:0] msg, output int lat);
        int n;
        msg = '0;
        lat = 0;
        n   = 0;
        @(negedge clk);
        while (!memreq_rdy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!memreq_rdy) begin
            check("req_accept_timeout", 67'(memreq_rdy), 67'(1));
            return;
        end
        memreq_val = 1'b1;
        memreq_msg = {typ, addr, len, data};
        @(posedge clk);
        #1 memreq_val = 1'b0;
        while (lat < 200) begin
            @(negedge clk);
            lat++;
            if (memresp_val) break;
        end
        msg = memresp_msg;
        if (!memresp_val) check("resp_timeout", 67'(memresp_val), 67'(1));
        @(posedge clk);
        #1;
    endtask

    typedef struct {
        logic        typ;
        logic [31:0] addr;
        logic [1:0]  len;
        logic [31:0] data;
        logic [31:0] exp_data;
        int          exp_lat;
        int          exp_reads;
        int          exp_hits;
        int          exp_misses;
    } vec_t;

    vec_t vecs [13];

    initial begin
        logic [34:0] msg;
        int          lat;
        int          r0;
        int          w0;
        int          done_at;
        int          done_cnt;
        logic        leak;
        logic [31:0] hits0;

        vecs[0]  = '{1'b0, 32'h1000, 2'd0, 32'h0,         32'hD000_1000, 10, 4, 0, 1};
        vecs[1]  = '{1'b0, 32'h1008, 2'd0, 32'h0,         32'hD000_1008,  2, 0, 1, 1};
        vecs[2]  = '{1'b0, 32'h2000, 2'd0, 32'h0,         32'hD000_2000, 10, 4, 1, 2};
        vecs[3]  = '{1'b0, 32'h1000, 2'd0, 32'h0,         32'hD000_1000, 10, 4, 1, 3};
        vecs[4]  = '{1'b1, 32'h1004, 2'd0, 32'hEEEE_0004, 32'h0,          4, 0, 1, 3};
        vecs[5]  = '{1'b0, 32'h1004, 2'd0, 32'h0,         32'hEEEE_0004,  2, 0, 2, 3};
        vecs[6]  = '{1'b1, 32'h3004, 2'd0, 32'h1234_5678, 32'h0,          4, 0, 2, 3};
        vecs[7]  = '{1'b0, 32'h3004, 2'd0, 32'h0,         32'h1234_5678, 10, 4, 2, 4};
        vecs[8]  = '{1'b0, 32'h1010, 2'd0, 32'h0,         32'hD000_1010, 10, 4, 2, 5};
        vecs[9]  = '{1'b0, 32'h1014, 2'd0, 32'h0,         32'hD000_1014,  2, 0, 3, 5};
        vecs[10] = '{1'b1, 32'h1018, 2'd1, 32'h0000_00AB, 32'h0,          4, 0, 3, 5};
        vecs[11] = '{1'b0, 32'h1014, 2'd0, 32'h0,         32'hD000_1014, 10, 4, 3, 6};
        vecs[12] = '{1'b0, 32'h1016, 2'd2, 32'h0,         32'hD000_1014,  2, 0, 4, 6};

        reset        = 1'b1;
        memreq_val   = 1'b0;
        memreq_msg   = '0;
        memresp_rdy  = 1'b1;
        cachereq_rdy = 1'b1;
        flush        = 1'b0;

        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check($sformatf("reset_outputs_%0d", k),
                  67'({memreq_rdy, memresp_val, cachereq_val, flush_done}), 67'(0));
        end
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rdy_after_reset", 67'(memreq_rdy), 67'(1));
        check("counters_after_reset", 67'({dut.num_hits, dut.num_misses}), 67'(0));
        @(posedge clk);
        #1;

        for (int i = 0; i < 13; i++) begin
            r0 = rd_log.size();
            w0 = wr_cnt;
            do_req(vecs[i].typ, vecs[i].addr, vecs[i].len, vecs[i].data, msg, lat);
            check($sformatf("v%0d_resp", i), 67'(msg),
                  67'({vecs[i].typ, vecs[i].len, vecs[i].typ ? 32'h0 : vecs[i].exp_data}));
            check($sformatf("v%0d_latency", i), 67'(lat), 67'(vecs[i].exp_lat));
            check($sformatf("v%0d_mem_reads", i), 67'(rd_log.size() - r0), 67'(vecs[i].exp_reads));
            check($sformatf("v%0d_mem_writes", i), 67'(wr_cnt - w0), 67'(vecs[i].typ));
            check($sformatf("v%0d_hits", i), 67'(dut.num_hits), 67'(vecs[i].exp_hits));
            check($sformatf("v%0d_misses", i), 67'(dut.num_misses), 67'(vecs[i].exp_misses));
            if (vecs[i].exp_reads == 4 && rd_log.size() >= r0 + 4) begin
                for (int k = 0; k < 4; k++)
                    check($sformatf("v%0d_refill_addr%0d", i, k), 67'(rd_log[r0+k]),
                          67'({vecs[i].addr[31:4], 4'h0} + 32'(4 * k)));
            end
            if (vecs[i].typ)
                check($sformatf("v%0d_write_fwd", i), last_wr,
                      {vecs[i].typ, vecs[i].addr, vecs[i].len, vecs[i].data});
        end

        // Backpressure on a hit while a second request is held on the input.
        memresp_rdy = 1'b0;
        hits0       = dut.num_hits;
        @(negedge clk);
        memreq_val = 1'b1;
        memreq_msg = {1'b0, 32'h1014, 2'b00, 32'h0};
        @(posedge clk);
        #1 memreq_msg = {1'b0, 32'h2000, 2'b00, 32'h0};
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check($sformatf("stall_cycle%0d", k), 67'({memresp_val, memreq_rdy, memresp_msg}),
                  67'({1'b1, 1'b0, 1'b0, 2'b00, 32'hD000_1014}));
        end
        @(posedge clk);
        #1;
        memreq_val  = 1'b0;
        memresp_rdy = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check("stall_release", 67'({memresp_val, memreq_rdy}), 67'({1'b0, 1'b1}));
        check("stall_single_hit", 67'(dut.num_hits - hits0), 67'(1));
        @(posedge clk);
        #1;

        // Flush from IDLE with a same-cycle request that must be refused.
        @(negedge clk);
        flush      = 1'b1;
        memreq_val = 1'b1;
        memreq_msg = {1'b0, 32'h1014, 2'b00, 32'h0};
        #1 check("flush_blocks_rdy", 67'(memreq_rdy), 67'(0));
        @(posedge clk);
        #1;
        flush      = 1'b0;
        memreq_val = 1'b0;
        done_at    = -1;
        done_cnt   = 0;
        leak       = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (flush_done) begin
                done_cnt++;
                if (done_at < 0) done_at = k;
            end else if (done_at < 0 && (memreq_rdy || memresp_val || cachereq_val)) begin
                leak = 1'b1;
            end
        end
        check("flush_done_cycle", 67'(done_at), 67'(16));
        check("flush_done_pulses", 67'(done_cnt), 67'(1));
        check("flush_quiet", 67'(leak), 67'(0));
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h1014, 2'b00, 32'h0, msg, lat);
        check("post_flush_resp", 67'(msg), 67'({1'b0, 2'b00, 32'hD000_1014}));
        check("post_flush_miss_lat", 67'(lat), 67'(10));

        // Flush raised in the middle of a refill.
        fork
            begin
                repeat (4) @(posedge clk);
                #1 flush = 1'b1;
                @(posedge clk);
                #1 flush = 1'b0;
            end
        join_none
        do_req(1'b0, 32'h5000, 2'b00, 32'h0, msg, lat);
        check("midflush_resp", 67'(msg), 67'({1'b0, 2'b00, 32'hD000_5000}));
        check("midflush_lat", 67'(lat), 67'(10));
        done_cnt = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (flush_done) done_cnt++;
        end
        check("midflush_done", 67'(done_cnt), 67'(1));
        @(posedge clk);
        #1;
        do_req(1'b0, 32'h5000, 2'b00, 32'h0, msg, lat);
        check("after_midflush_resp", 67'(msg), 67'({1'b0, 2'b00, 32'hD000_5000}));
        check("after_midflush_lat", 67'(lat), 67'(10));

        check("final_hits", 67'(dut.num_hits), 67'(5));
        check("final_misses", 67'(dut.num_misses), 67'(9));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
